// File: rtl/rr_mux_sel_arbiter.sv
// -----------------------------------------------------------------------------
// rr_mux_sel_arbiter
//
// Round-robin select generator for a 4:1 single-bit mux. Four requesters
// compete for the mux. One winner at a time owns it for a bounded dwell, so
// the mux output stays stable while a channel holds the grant.
//
// Parameters:
//   HOLD_MAX - maximum grant dwell in cycles (1..15)
//   CNT_W    - dwell counter width, 2**CNT_W > HOLD_MAX
//
// Ports:
//   clk    in   1  rising-edge clock
//   rst_n  in   1  synchronous active-low reset
//   req    in   4  per-channel request, req[i] asks for mux input i
//   done   in   1  owner releases early (ignored while idle)
//   sel    out  2  binary index of the owning / last-owning channel
//   grant  out  4  one-hot grant, zero while idle
//   busy   out  1  a grant is active
// -----------------------------------------------------------------------------
module rr_mux_sel_arbiter #(
  parameter int HOLD_MAX = 8,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       done,
  output logic [1:0] sel,
  output logic [3:0] grant,
  output logic       busy
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_MAX - 1);

  state_t           state_reg, state_next;
  logic [1:0]       sel_reg, sel_next;
  logic [1:0]       last_reg, last_next;
  logic [3:0]       grant_reg, grant_next;
  logic             busy_reg, busy_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;

  // Search base: while granting, a release makes the current owner the new
  // "last", so the scan is rooted at sel_reg; while idle it is rooted at
  // last_reg (which already equals the last released index).
  logic [1:0] base;
  logic [3:0] rot_req;
  logic [1:0] rot_idx;
  logic [1:0] winner;
  logic       any_req;
  logic       release_now;

  assign base    = (state_reg == GRANT) ? sel_reg : last_reg;
  assign any_req = |req;

  // rot_req[k] is the request of channel (base + 1 + k) mod 4, so index 0 is
  // the highest-priority position and index 3 is the base channel itself.
  for (genvar gi = 0; gi < 4; gi++) begin : g_rot
    assign rot_req[gi] = req[base + 2'(gi + 1)];
  end

  always_comb begin
    rot_idx = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (rot_req[k]) rot_idx = 2'(k);
    end
  end

  assign winner = base + 2'd1 + rot_idx;

  assign release_now = (state_reg == GRANT) &&
                       (done || !req[sel_reg] || (cnt_reg == CNT_LAST));

  always_comb begin
    state_next = state_reg;
    sel_next   = sel_reg;
    last_next  = last_reg;
    grant_next = grant_reg;
    busy_next  = busy_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (any_req) begin
          state_next = GRANT;
          sel_next   = winner;
          grant_next = 4'b0001 << winner;
          busy_next  = 1'b1;
          cnt_next   = '0;
        end
      end
      GRANT: begin
        if (release_now) begin
          last_next = sel_reg;
          if (any_req) begin
            // Back-to-back handover (possibly to the same owner).
            sel_next   = winner;
            grant_next = 4'b0001 << winner;
            cnt_next   = '0;
          end else begin
            state_next = IDLE;
            grant_next = 4'b0000;
            busy_next  = 1'b0;
            cnt_next   = '0;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      sel_reg   <= 2'b00;
      last_reg  <= 2'b11;
      grant_reg <= 4'b0000;
      busy_reg  <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      sel_reg   <= sel_next;
      last_reg  <= last_next;
      grant_reg <= grant_next;
      busy_reg  <= busy_next;
      cnt_reg   <= cnt_next;
    end
  end

  assign sel   = sel_reg;
  assign grant = grant_reg;
  assign busy  = busy_reg;

endmodule

// File: tb/tb_rr_mux_sel_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rr_mux_sel_arbiter
//
// Directed bench. Each stimulus step drives one cycle of inputs and pushes
// the hand-derived outputs expected after the following rising edge. A
// separate monitor pops one expectation per cycle on the falling edge and
// compares sel, grant and busy.
// -----------------------------------------------------------------------------
module tb_rr_mux_sel_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic       done;
  logic [1:0] sel;
  logic [3:0] grant;
  logic       busy;

  typedef struct {
    int         step_no;
    logic [1:0] sel;
    logic [3:0] grant;
    logic       busy;
  } exp_t;

  exp_t exp_q[$];
  int   step_cnt  = 0;
  int   chk_cnt   = 0;
  int   pass_cnt  = 0;

  always #5 clk = ~clk;

  rr_mux_sel_arbiter #(.HOLD_MAX(8), .CNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .done  (done),
    .sel   (sel),
    .grant (grant),
    .busy  (busy)
  );

  // Drive one cycle of inputs and queue the outputs expected after the edge.
  task automatic step(input logic r, input logic [3:0] rq, input logic d,
                      input logic [1:0] es, input logic [3:0] eg, input logic eb);
    exp_t e;
    rst_n = r;
    req   = rq;
    done  = d;
    step_cnt++;
    e.step_no = step_cnt;
    e.sel     = es;
    e.grant   = eg;
    e.busy    = eb;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Monitor: outputs are registered, so every cycle presents a result.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk_cnt++;
      if (sel !== e.sel)
        $display("FAIL step %0d sel: got %0d expected %0d", e.step_no, sel, e.sel);
      else pass_cnt++;
      chk_cnt++;
      if (grant !== e.grant)
        $display("FAIL step %0d grant: got %b expected %b", e.step_no, grant, e.grant);
      else pass_cnt++;
      chk_cnt++;
      if (busy !== e.busy)
        $display("FAIL step %0d busy: got %b expected %b", e.step_no, busy, e.busy);
      else pass_cnt++;
      $display("step %0d: req=%b done=%b -> sel=%0d grant=%b busy=%b",
               e.step_no, req, done, sel, grant, busy);
    end
  end

  initial begin
    // Reset held two cycles with every input active.
    step(1'b0, 4'b1111, 1'b1, 2'd0, 4'b0000, 1'b0);
    step(1'b0, 4'b1111, 1'b1, 2'd0, 4'b0000, 1'b0);

    // Full load: 0,1,2,3,0 each for exactly 8 cycles, no gaps.
    // The first ch0 cycle is also the first edge after reset release.
    for (int ch = 0; ch < 5; ch++) begin
      for (int c = 0; c < 8; c++) begin
        step(1'b1, 4'b1111, 1'b0, 2'(ch % 4), 4'b0001 << (ch % 4), 1'b1);
      end
    end

    // Reset again, then a lone requester on ch0.
    step(1'b0, 4'b1111, 1'b0, 2'd0, 4'b0000, 1'b0);
    // 8-cycle grant, then re-granted; 3 cycles into the re-grant ch1 joins.
    for (int c = 0; c < 11; c++) step(1'b1, 4'b0001, 1'b0, 2'd0, 4'b0001, 1'b1);
    // Re-grant must still run its full 8 cycles (counter restarted at 0).
    for (int c = 0; c < 5; c++)  step(1'b1, 4'b0011, 1'b0, 2'd0, 4'b0001, 1'b1);
    step(1'b1, 4'b0011, 1'b0, 2'd1, 4'b0010, 1'b1);   // ch1 cycle 1

    // Early done in the 3rd cycle of the ch1 grant.
    step(1'b1, 4'b0110, 1'b0, 2'd1, 4'b0010, 1'b1);   // ch1 cycle 2
    step(1'b1, 4'b0110, 1'b0, 2'd1, 4'b0010, 1'b1);   // ch1 cycle 3
    step(1'b1, 4'b0110, 1'b1, 2'd2, 4'b0100, 1'b1);   // done -> ch2

    // Request drop: idle with sel held at 2; done is ignored while idle.
    step(1'b1, 4'b0100, 1'b0, 2'd2, 4'b0100, 1'b1);
    step(1'b1, 4'b0000, 1'b0, 2'd2, 4'b0000, 1'b0);
    step(1'b1, 4'b0000, 1'b1, 2'd2, 4'b0000, 1'b0);
    // Scan starts at 3 (idle), ch0 wins over ch2.
    step(1'b1, 4'b0101, 1'b0, 2'd0, 4'b0001, 1'b1);

    // ch0 drops, handover to ch2; then reset mid-grant.
    step(1'b1, 4'b0100, 1'b0, 2'd2, 4'b0100, 1'b1);
    step(1'b1, 4'b0100, 1'b0, 2'd2, 4'b0100, 1'b1);
    step(1'b0, 4'b0100, 1'b1, 2'd0, 4'b0000, 1'b0);
    step(1'b0, 4'b1001, 1'b0, 2'd0, 4'b0000, 1'b0);
    // After reset ch0 beats ch3, holds 8 cycles, then ch3.
    for (int c = 0; c < 8; c++) step(1'b1, 4'b1001, 1'b0, 2'd0, 4'b0001, 1'b1);
    step(1'b1, 4'b1001, 1'b0, 2'd3, 4'b1000, 1'b1);
    step(1'b1, 4'b1000, 1'b0, 2'd3, 4'b1000, 1'b1);
    step(1'b1, 4'b0000, 1'b0, 2'd3, 4'b0000, 1'b0);
    // last=3 after release: ch0 first from idle.
    step(1'b1, 4'b1111, 1'b0, 2'd0, 4'b0001, 1'b1);

    // Let the monitor drain the final expectation.
    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/rr_mux_sel_arbiter.md
Name: rr_mux_sel_arbiter

Overview:
- Round-robin select generator that sits directly upstream of the team's 4:1 single-bit mux and drives its 2-bit select.
- Four request lines compete for the mux. One channel is granted at a time and held for a bounded dwell, so the mux output is stable while a channel owns it.
- Outputs: binary select (to the mux), one-hot grant (back to the requesters), and a busy flag.

Parameters:
- HOLD_MAX, 8, maximum grant dwell in cycles; legal range 1..15.
- CNT_W, 4, dwell counter width; must satisfy 2^CNT_W > HOLD_MAX.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset, synchronous and active-low.
- req  input  4  per-channel request; req[i] asks for mux input i.
- done  input  1  current owner releases early; sampled only while busy=1.
- sel  output  2  mux select, binary index of the owning or last-owning channel.
- grant  output  4  one-hot grant; all zero when idle.
- busy  output  1  a grant is active.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - sel=2'b00, grant=4'b0000, busy=0, cnt=0, state=IDLE.
  - Internal last-owner pointer last=3, so channel 0 has top priority after reset.
  - Reset asserted mid-grant takes effect at the next edge regardless of req/done.
- States: IDLE, GRANT.
- Priority search:
  - Starts at (last+1) mod 4 and scans cyclically through 4 entries.
  - The first i with req[i]=1 wins. The current or last owner is therefore lowest priority but still eligible.
- IDLE:
  - If req != 0: next edge goes to GRANT with sel=winner, grant=1<<winner, busy=1, cnt=0.
  - Latency from req high to grant is 1 cycle.
  - If req == 0: stay in IDLE; sel holds its last value; grant=0; busy=0.
  - done is ignored in IDLE.
- GRANT, per cycle:
  - The release condition is evaluated combinationally from registered state and current inputs.
  - Release when done=1, OR req[sel]=0, OR cnt==HOLD_MAX-1. Any combination of these is a single release event.
  - No release: cnt increments; sel and grant hold.
  - Release with another request pending: last takes the value of sel, and the priority search runs using the updated last. At the next edge the new winner is granted with cnt=0 and no idle cycle in between.
  - Release with no request pending (after masking nothing): go to IDLE with grant=0 and busy=0; sel keeps the released index; last takes the value of sel.
  - If the owner is the only requester when the timeout hits, it is re-granted back-to-back and cnt restarts at 0.
- Dwell:
  - With no early release, a grant lasts exactly HOLD_MAX cycles.
  - HOLD_MAX=1 gives a one-cycle grant per channel.
- Output invariants:
  - grant is either zero or one-hot, and when busy=1, grant[sel]=1.
  - sel changes only at grant boundaries.
  - All outputs are registered.
- Counter: cnt never exceeds HOLD_MAX-1 and cannot wrap.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with req=4'b1111 and done=1 -> sel=0, grant=0, busy=0 throughout. First edge after release gives grant=4'b0001.
- Single requester: req=4'b0001 held -> grant=0001 one cycle later for 8 cycles, then re-granted back-to-back (busy never drops), cnt restarts.
- Full load: req=4'b1111 held -> sel sequence 0,1,2,3,0, each exactly 8 cycles, no gaps, grant always one-hot and matching sel.
- Early done: req=4'b0110, pulse done in the 3rd cycle of the ch1 grant -> the next cycle has sel=2, grant=0100.
- Request drop and rotation:
  - req=4'b0100 granted, then req drops to 0 -> next cycle busy=0, grant=0, sel stays 2.
  - Then req=4'b0101 -> sel=0 (scan starts at 3, ch3 is idle, ch0 wins).
- Reset mid-grant: rst_n=0 during a ch2 grant -> next edge all outputs zero. After release, req=4'b1001 -> ch0 granted first.
